// File: rtl/pll_ctrl_pkg.sv
// Shared types and default divider tables for the HDMI rPLL mode sequencer.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_PLL   = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2,
        FAIL      = 2'd3
    } pll_state_e;

    localparam int MODE_VGA  = 0;
    localparam int MODE_720P = 1;

    // Packed 6-bit codes, mode 0 in the least significant slot.
    localparam logic [11:0] DEF_IDSEL_TABLE  = {6'd60, 6'd61};
    localparam logic [11:0] DEF_FBDSEL_TABLE = {6'd9,  6'd50};
    localparam logic [11:0] DEF_ODSEL_TABLE  = {6'd62, 6'd62};

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser for the raw rPLL LOCK plus a saturating debounce counter.
module pll_lock_filter #(
    parameter int LOCK_STABLE = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic clear,
    output logic lock_s,
    output logic lock_ok
);

    localparam int ST_W = $clog2(LOCK_STABLE + 1);

    logic            lock_meta_q;
    logic            lock_s_q;
    logic [ST_W-1:0] stable_q;
    logic [ST_W-1:0] stable_d;

    assign stable_d = (stable_q == ST_W'(LOCK_STABLE)) ? stable_q : stable_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            stable_q    <= '0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            if (clear || !lock_s_q) begin
                stable_q <= '0;
            end else begin
                stable_q <= stable_d;
            end
        end
    end

    assign lock_s  = lock_s_q;
    // Asserted in the cycle whose edge brings the count to LOCK_STABLE.
    assign lock_ok = lock_s_q && (stable_q >= ST_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/hdmi_pll_mode_ctrl.sv
// Run-time mode sequencer for a Gowin rPLL with dynamic dividers.
// Optional PLL_UNLOCK_COUNT_EN adds an unlock event counter output.
module hdmi_pll_mode_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                      NUM_MODES    = 2,
    parameter int                      MODE_W       = 1,
    parameter int                      DEFAULT_MODE = MODE_720P,
    parameter logic [6*NUM_MODES-1:0]  IDSEL_TABLE  = DEF_IDSEL_TABLE,
    parameter logic [6*NUM_MODES-1:0]  FBDSEL_TABLE = DEF_FBDSEL_TABLE,
    parameter logic [6*NUM_MODES-1:0]  ODSEL_TABLE  = DEF_ODSEL_TABLE,
    parameter int                      RESET_CYCLES = 32,
    parameter int                      LOCK_STABLE  = 256,
    parameter int                      LOCK_TIMEOUT = 65536,
    parameter int                      MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_req_valid,
    input  logic [MODE_W-1:0] mode_req,
    output logic              mode_req_ready,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic [MODE_W-1:0] cur_mode,
    output logic              clk_ok,
    output logic              pll_fail
`ifdef PLL_UNLOCK_COUNT_EN
    ,
    output logic [7:0]        unlock_cnt
`endif
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    function automatic logic [5:0] pick(input logic [6*NUM_MODES-1:0] tbl,
                                        input logic [MODE_W-1:0]      m);
        return 6'(tbl >> (6 * int'(m)));
    endfunction

    pll_state_e        state_q;
    logic              pll_reset_q;
    logic [5:0]        idsel_q;
    logic [5:0]        fbdsel_q;
    logic [5:0]        odsel_q;
    logic [MODE_W-1:0] cur_mode_q;
    logic              clk_ok_q;
    logic              fail_q;
    logic              ready_q;
    logic [RC_W-1:0]   rst_cnt_q;
    logic [RC_W-1:0]   rst_cnt_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;
    logic [RT_W-1:0]   retry_q;
    logic [RT_W-1:0]   retry_d;
`ifdef PLL_UNLOCK_COUNT_EN
    logic [7:0]        unlock_q;
`endif

    logic lock_s;
    logic lock_ok;
    logic mode_valid;
    logic reprog;

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .clear    (state_q == RST_PLL),
        .lock_s   (lock_s),
        .lock_ok  (lock_ok)
    );

    assign rst_cnt_d = (rst_cnt_q == RC_W'(RESET_CYCLES)) ? rst_cnt_q : rst_cnt_q + 1'b1;
    assign to_cnt_d  = (to_cnt_q == TO_W'(LOCK_TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
    assign retry_d   = (retry_q == RT_W'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;

    // Ready is only ever high in LOCKED or FAIL; FAIL restarts even on the current mode.
    assign mode_valid = int'(mode_req) < NUM_MODES;
    assign reprog     = mode_req_valid && ready_q && mode_valid &&
                        ((state_q == FAIL) || (mode_req != cur_mode_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RST_PLL;
            pll_reset_q <= 1'b1;
            cur_mode_q  <= MODE_W'(DEFAULT_MODE);
            idsel_q     <= pick(IDSEL_TABLE,  MODE_W'(DEFAULT_MODE));
            fbdsel_q    <= pick(FBDSEL_TABLE, MODE_W'(DEFAULT_MODE));
            odsel_q     <= pick(ODSEL_TABLE,  MODE_W'(DEFAULT_MODE));
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
            ready_q     <= 1'b0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
`ifdef PLL_UNLOCK_COUNT_EN
            unlock_q    <= '0;
`endif
        end else if (reprog) begin
            state_q     <= RST_PLL;
            pll_reset_q <= 1'b1;
            cur_mode_q  <= mode_req;
            idsel_q     <= pick(IDSEL_TABLE,  mode_req);
            fbdsel_q    <= pick(FBDSEL_TABLE, mode_req);
            odsel_q     <= pick(ODSEL_TABLE,  mode_req);
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
            ready_q     <= 1'b0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
`ifdef PLL_UNLOCK_COUNT_EN
            unlock_q    <= '0;
`endif
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                        state_q     <= WAIT_LOCK;
                        pll_reset_q <= 1'b0;
                        rst_cnt_q   <= '0;
                        to_cnt_q    <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_d;
                    end
                end
                WAIT_LOCK: begin
                    // Timeout wins over a lock that matures in the same cycle.
                    if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                        to_cnt_q    <= '0;
                        pll_reset_q <= 1'b1;
                        if (retry_q < RT_W'(MAX_RETRY)) begin
                            retry_q   <= retry_d;
                            rst_cnt_q <= '0;
                            state_q   <= RST_PLL;
                        end else begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (lock_ok) begin
                            state_q  <= LOCKED;
                            clk_ok_q <= 1'b1;
                            ready_q  <= 1'b1;
                            retry_q  <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        state_q  <= WAIT_LOCK;
                        clk_ok_q <= 1'b0;
                        ready_q  <= 1'b0;
                        to_cnt_q <= '0;
`ifdef PLL_UNLOCK_COUNT_EN
                        unlock_q <= (unlock_q == 8'hFF) ? unlock_q : unlock_q + 1'b1;
`endif
                    end
                end
                FAIL: begin
                end
                default: state_q <= RST_PLL;
            endcase
        end
    end

    assign mode_req_ready = ready_q;
    assign pll_reset      = pll_reset_q;
    assign pll_idsel      = idsel_q;
    assign pll_fbdsel     = fbdsel_q;
    assign pll_odsel      = odsel_q;
    assign cur_mode       = cur_mode_q;
    assign clk_ok         = clk_ok_q;
    assign pll_fail       = fail_q;
`ifdef PLL_UNLOCK_COUNT_EN
    assign unlock_cnt     = unlock_q;
`endif

endmodule

// File: tb/tb_hdmi_pll_mode_ctrl.sv
// Scoreboard bench for hdmi_pll_mode_ctrl; debounce and timeout shortened to keep runtime small.
module tb_hdmi_pll_mode_ctrl;

    localparam int NM     = 2;
    localparam int MW     = 2;
    localparam int RC     = 32;
    localparam int STABLE = 64;
    localparam int TO     = 1024;
    localparam int MR     = 3;
    localparam int BOUND  = 6000;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode_req_valid;
    logic [MW-1:0] mode_req;
    logic          mode_req_ready;
    logic          pll_lock;
    logic          pll_reset;
    logic [5:0]    pll_idsel;
    logic [5:0]    pll_fbdsel;
    logic [5:0]    pll_odsel;
    logic [MW-1:0] cur_mode;
    logic          clk_ok;
    logic          pll_fail;
`ifdef PLL_UNLOCK_COUNT_EN
    logic [7:0]    unlock_cnt;
`endif

    hdmi_pll_mode_ctrl #(
        .NUM_MODES    (NM),
        .MODE_W       (MW),
        .DEFAULT_MODE (1),
        .RESET_CYCLES (RC),
        .LOCK_STABLE  (STABLE),
        .LOCK_TIMEOUT (TO),
        .MAX_RETRY    (MR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .pll_idsel      (pll_idsel),
        .pll_fbdsel     (pll_fbdsel),
        .pll_odsel      (pll_odsel),
        .cur_mode       (cur_mode),
        .clk_ok         (clk_ok),
        .pll_fail       (pll_fail)
`ifdef PLL_UNLOCK_COUNT_EN
        ,
        .unlock_cnt     (unlock_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles pll_reset stays high, and cycles where the dividers differ from the expected set.
    task automatic measure_reset(input logic [5:0] ei, input logic [5:0] ef, input logic [5:0] eo,
                                 output int n, output int bad);
        n   = 0;
        bad = 0;
        while (pll_reset === 1'b1 && n < BOUND) begin
            if (pll_idsel !== ei || pll_fbdsel !== ef || pll_odsel !== eo) bad++;
            n++;
            tick();
        end
    endtask

    task automatic wait_ok(input logic lvl, output int n, output int rst_hi);
        n      = 0;
        rst_hi = 0;
        while (clk_ok !== lvl && n < BOUND) begin
            tick();
            n++;
            if (pll_reset !== 1'b0) rst_hi++;
        end
    endtask

    task automatic send_req(input logic [MW-1:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
    endtask

    // Holds reset low-to-lock sequence: pll_reset window, then lock 100 cycles later, then debounce.
    task automatic bring_up(input string nm, input logic [5:0] ei, input logic [5:0] ef, input logic [5:0] eo);
        int n, bad, rh;
        expect_v({nm, "_rst_len"}, RC);
        expect_v({nm, "_div_stable"}, 0);
        measure_reset(ei, ef, eo, n, bad);
        observe(n);
        observe(bad);
        repeat (100) tick();
        expect_v({nm, "_early_ok"}, 0);
        observe(clk_ok);
        pll_lock = 1'b1;
        expect_v({nm, "_lock_lat"}, 2 + STABLE);
        wait_ok(1'b1, n, rh);
        observe(n);
        expect_v({nm, "_ready"}, 1);
        observe(mode_req_ready);
    endtask

    initial begin
        int n, rh, rises;
        logic prev;

        reset          = 1'b1;
        mode_req_valid = 1'b0;
        mode_req       = '0;
        pll_lock       = 1'b0;
        repeat (3) tick();

        expect_v("rst_pll_reset", 1);   observe(pll_reset);
        expect_v("rst_cur_mode", 1);    observe(cur_mode);
        expect_v("rst_idsel", 60);      observe(pll_idsel);
        expect_v("rst_fbdsel", 9);      observe(pll_fbdsel);
        expect_v("rst_odsel", 62);      observe(pll_odsel);
        expect_v("rst_clk_ok", 0);      observe(clk_ok);
        expect_v("rst_fail", 0);        observe(pll_fail);
        expect_v("rst_ready", 0);       observe(mode_req_ready);

        reset = 1'b0;
        bring_up("boot", 6'd60, 6'd9, 6'd62);

        // Mode change to VGA while locked.
        expect_v("m0_pll_reset", 1);
        expect_v("m0_clk_ok", 0);
        expect_v("m0_idsel", 61);
        expect_v("m0_fbdsel", 50);
        expect_v("m0_ready", 0);
        send_req(2'd0);
        pll_lock = 1'b0;
        observe(pll_reset);
        observe(clk_ok);
        observe(pll_idsel);
        observe(pll_fbdsel);
        observe(mode_req_ready);
        bring_up("m0", 6'd61, 6'd50, 6'd62);
        expect_v("m0_cur_mode", 0);
        observe(cur_mode);

        // Lock loss in LOCKED: no reset pulse, relock on the same dividers.
        pll_lock = 1'b0;
        expect_v("drop_lat", 3);
        wait_ok(1'b0, n, rh);
        observe(n);
        repeat (20) tick();
        pll_lock = 1'b1;
        expect_v("relock_lat", 2 + STABLE);
        expect_v("relock_no_rst", 0);
        wait_ok(1'b1, n, rh);
        observe(n);
        observe(rh);
        expect_v("relock_idsel", 61);
        observe(pll_idsel);

        // Single-cycle glitch during debounce restarts the count.
        pll_lock = 1'b0;
        wait_ok(1'b0, n, rh);
        repeat (5) tick();
        pll_lock = 1'b1;
        repeat (2 + 50) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        expect_v("glitch_lat", 2 + STABLE);
        wait_ok(1'b1, n, rh);
        observe(n);

        // Same-mode request while LOCKED is a no-op.
        expect_v("same_ready", 1);      observe(mode_req_ready);
        send_req(2'd0);
        expect_v("same_ready_after", 1); observe(mode_req_ready);
        expect_v("same_clk_ok", 1);     observe(clk_ok);
        expect_v("same_pll_reset", 0);  observe(pll_reset);

        // Out-of-range mode is accepted and ignored.
        send_req(2'd3);
        repeat (3) tick();
        expect_v("oor_ready", 1);       observe(mode_req_ready);
        expect_v("oor_clk_ok", 1);      observe(clk_ok);
        expect_v("oor_cur_mode", 0);    observe(cur_mode);
        expect_v("oor_idsel", 61);      observe(pll_idsel);
        expect_v("oor_pll_reset", 0);   observe(pll_reset);

        // Reset mid-operation.
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick();
        expect_v("mid_rst_pll_reset", 1); observe(pll_reset);
        expect_v("mid_rst_clk_ok", 0);    observe(clk_ok);
        expect_v("mid_rst_cur_mode", 1);  observe(cur_mode);
        expect_v("mid_rst_idsel", 60);    observe(pll_idsel);
        expect_v("mid_rst_ready", 0);     observe(mode_req_ready);
        reset = 1'b0;

        // Lock never arrives: four attempts then FAIL.
        expect_v("fail_time", 4 * (RC + TO));
        expect_v("fail_rst_rises", MR + 1);
        n     = 0;
        rises = 0;
        prev  = pll_reset;
        while (pll_fail !== 1'b1 && n < 5 * (RC + TO)) begin
            tick();
            n++;
            if (pll_reset === 1'b1 && prev === 1'b0) rises++;
            prev = pll_reset;
        end
        observe(n);
        observe(rises);
        repeat (10) tick();
        expect_v("fail_hold", 1);       observe(pll_fail);
        expect_v("fail_pll_reset", 1);  observe(pll_reset);
        expect_v("fail_clk_ok", 0);     observe(clk_ok);
        expect_v("fail_ready", 1);      observe(mode_req_ready);

        send_req(2'd1);
        expect_v("unfail_fail", 0);     observe(pll_fail);
        expect_v("unfail_ready", 0);    observe(mode_req_ready);
        bring_up("unfail", 6'd60, 6'd9, 6'd62);

`ifdef PLL_UNLOCK_COUNT_EN
        expect_v("unlock_start", 0);
        observe(unlock_cnt);
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            wait_ok(1'b0, n, rh);
            pll_lock = 1'b1;
            wait_ok(1'b1, n, rh);
        end
        expect_v("unlock_sat", 255);
        observe(unlock_cnt);
        send_req(2'd0);
        expect_v("unlock_clear", 0);
        observe(unlock_cnt);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
